// File: rtl/word_serializer_pkg.sv
// Shared types and defaults for the word serializer: FSM state encoding,
// default parameters and the tick-counter width helper.
package serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_DEF    = 16;
    localparam int BIT_CLKS_DEF = 4;

    // A counter for a single-clock bit period still needs one bit of storage.
    function automatic int tick_width(input int bit_clks);
        if (bit_clks <= 2) begin
            return 1;
        end else begin
            return $clog2(bit_clks);
        end
    endfunction

endpackage

// File: rtl/word_serializer_bit_timer.sv
// Bit-period timer: counts clocks while run is high and pulses tick on the
// clock where the count wraps, i.e. the last clock of each bit period.
module bit_timer
    import serializer_pkg::*;
#(
    parameter int BIT_CLKS = BIT_CLKS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int            TW   = tick_width(BIT_CLKS);
    localparam logic [TW-1:0] LAST = TW'(BIT_CLKS - 1);

    logic [TW-1:0] r_cnt;
    logic [TW-1:0] w_cnt_nxt;
    logic          w_wrap;

    // Next count: clear when idle, wrap at the end of a bit period.
    always_comb begin
        w_wrap    = run && (r_cnt == LAST);
        w_cnt_nxt = r_cnt;
        if (!run) begin
            w_cnt_nxt = {TW{1'b0}};
        end else if (w_wrap) begin
            w_cnt_nxt = {TW{1'b0}};
        end else begin
            w_cnt_nxt = r_cnt + TW'(1);
        end
    end

    // Tick counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= {TW{1'b0}};
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign tick = w_wrap;

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial readout: captures a word on ld, shifts it out MSB-first
// holding each bit BIT_CLKS clocks, then pulses done for one cycle.
module word_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int BIT_CLKS = BIT_CLKS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] D,
    input  logic             ld,
    output logic             sdo,
    output logic             frame,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [BW-1:0]    r_bitcnt;
    logic [BW-1:0]    w_bitcnt_nxt;
    logic             w_tick;
    logic             w_run;
    logic             r_sdo;
    logic             r_frame;
    logic             r_busy;
    logic             r_done;

    assign w_run = (r_state == SHIFT);

    bit_timer #(
        .BIT_CLKS (BIT_CLKS)
    ) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .run   (w_run),
        .tick  (w_tick)
    );

    // Next-state, shift register and bit counter.
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        case (r_state)
            IDLE: begin
                if (ld) begin
                    w_state_nxt  = SHIFT;
                    w_shift_nxt  = D;
                    w_bitcnt_nxt = BW'(WIDTH - 1);
                end else begin
                    w_state_nxt  = IDLE;
                end
            end
            SHIFT: begin
                if (w_tick) begin
                    w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
                    if (r_bitcnt == {BW{1'b0}}) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt - BW'(1);
                    end
                end else begin
                    w_state_nxt = SHIFT;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs derived from the next state,
    // so sdo never has a combinational path from D.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_shift  <= {WIDTH{1'b0}};
            r_bitcnt <= {BW{1'b0}};
            r_sdo    <= 1'b0;
            r_frame  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_sdo    <= (w_state_nxt == SHIFT) ? w_shift_nxt[WIDTH-1] : 1'b0;
            r_frame  <= (w_state_nxt == SHIFT);
            r_busy   <= (w_state_nxt != IDLE);
            r_done   <= (w_state_nxt == DONE);
        end
    end

    assign sdo   = r_sdo;
    assign frame = r_frame;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: doc/word_serializer.md
# word_serializer

Parallel-to-serial readout unit that drains a 16-bit word, such as a loadable register's Q output, onto a single-bit line. A one-cycle `ld` strobe captures the word. The block then shifts it out MSB-first, holding each bit for a programmable number of clocks. It flags completion with a one-cycle `done` pulse. It is the consuming end of the load path: the loadable register writes the word, and this block reads it out serially toward a display, LED, or pin-level link.

## Interface
- `WIDTH`, default 16: word width in bits; must be ≥ 2.
- `BIT_CLKS`, default 4: clocks each bit is held on `sdo`; must be ≥ 1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  reset, asynchronous assertion, active-low. 0 forces all state and outputs to reset values immediately.
- `D`  in  WIDTH  parallel word; sampled only on the load edge.
- `ld`  in  1  load request; high-active; honoured only in IDLE.
- `sdo`  out  1  serial data, MSB first.
- `frame`  out  1  high while a word is being shifted.
- `busy`  out  1  high in SHIFT and DONE; `ld` is ignored while busy.
- `done`  out  1  one-cycle pulse after the last bit period.

## Operation
- States: IDLE, SHIFT, DONE.
- Reset values: state=IDLE, shift register=0, bit counter=0, tick counter=0, `sdo`=0, `frame`=0, `busy`=0, `done`=0.
- IDLE:
  - `ld`=1 → shift register←D, bit counter←WIDTH-1, tick counter←0, next state SHIFT.
  - `ld`=0 → hold every register (Q←Q behaviour).
- SHIFT:
  - `sdo` = shift register MSB (registered output; no combinational path from `D`).
  - Tick counter increments each clock. At BIT_CLKS-1 it wraps to 0 and the shift register shifts left one, filling 0.
  - When the bit counter is 0 and the tick counter wraps, next state is DONE. Otherwise the bit counter decrements on each wrap.
- DONE: `done`=1, `frame`=0, `sdo`=0, for exactly one cycle, then IDLE.
- `ld` asserted in SHIFT or DONE is dropped, not queued.
- Changes on `D` after the load edge have no effect on the word in flight.
- Reset during any state aborts the transfer with no `done` pulse. The state after reset release is IDLE.
- Counter widths: bit counter is $clog2(WIDTH) bits; tick counter is max(1,$clog2(BIT_CLKS)) bits. No counter overflows within legal parameters.
- BIT_CLKS=1: the tick counter wraps every cycle, so the block shifts one bit per clock.

## Timing
- Load edge at cycle k (`ld`=1 in IDLE): `frame`=`busy`=1 and `sdo`=D[WIDTH-1] from cycle k+1.
- Bit i (MSB = bit 0 in send order) is on `sdo` during cycles k+1+i·BIT_CLKS through k+(i+1)·BIT_CLKS.
- `done`=1 in cycle k+1+WIDTH·BIT_CLKS; `busy` is still 1 in that cycle.
- The earliest next accepted `ld` is at the edge ending cycle k+2+WIDTH·BIT_CLKS, one IDLE cycle after DONE.
- With `ld` held high continuously, words repeat with a period of WIDTH·BIT_CLKS+2 cycles.
- Reset is asynchronous: outputs drop in the same cycle `reset` falls. Release is synchronous in effect; the first edge after release sees IDLE.

## Structure
- Package `serializer_pkg`:
  - state enum {IDLE, SHIFT, DONE}.
  - Default constants WIDTH_DEF=16, BIT_CLKS_DEF=4.
- Sub-module `bit_timer`:
  - Parameterised by BIT_CLKS.
  - Inputs: `clk`, `reset`, `run`.
  - Output: one-cycle `tick` on tick-counter wrap.
  - Clears when `run`=0.
- The top level holds the FSM, the shift register and the bit counter.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `ld`=1 and D=16'hFFFF → `sdo`, `frame`, `busy` and `done` all stay 0; state is IDLE after release.
- Basic word: WIDTH=16, BIT_CLKS=4, D=16'hA5C3, `ld` pulse at cycle k → `sdo` carries 1010_0101_1100_0011 with each bit held 4 cycles from k+1; `done` is high only at k+65.
- Ignored load: during the transfer above, pulse `ld` with D=16'hFFFF at k+20 → serial output unchanged, a single `done`, and no second frame.
- Mid-transfer reset: drive `reset` low at k+23 (bit 5 in progress) → all outputs 0 in that cycle and no `done` pulse. A new `ld` with D=16'h0001 after release produces 15 zeros then a 1.
- Back-to-back: BIT_CLKS=1, `ld` held high with D=16'h8001 → frames repeat every 18 cycles, and `sdo` reads 1, 0×14, 1 in each frame.
- D stability: change `D` every cycle after the load edge → the output matches the word captured at the load edge.
